// File: rtl/tdm_mux_16x1_pkg.sv
// Shared types for the 16:1 TDM collector and its companion 1:16 demux.
// The demux side imports sel_t from here so both ends agree on the select width.
package tdm_pkg;

  localparam int N_CH   = 16;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 1;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  chan_vec_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic chan_vec_t sel_onehot(input sel_t idx);
    return chan_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/tdm_mux_16x1_if.sv
// Channel-request side and output side of the 16:1 TDM collector.
// The mux uses the slave modport; whoever feeds channels and drains the output uses master.
interface tdm_mux_16x1_if;
  import tdm_pkg::*;

  chan_vec_t                 in_valid;
  logic [N_CH*DATA_W-1:0]    in_data;
  chan_vec_t                 in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  sel_t                      out_sel;
  logic                      out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

endinterface

// File: rtl/tdm_mux_16x1_rr_pick16.sv
// Rotating-priority picker: first requester at or after ptr, wrapping 15 -> 0.
module rr_pick16
  import tdm_pkg::*;
(
  input  chan_vec_t req,
  input  sel_t      ptr,
  output sel_t      gnt_idx,
  output logic      any
);

  chan_vec_t rot;
  sel_t      offset;

  // Rotating right by ptr puts channel ptr at bit 0, so the lowest set bit is the winner.
  assign rot = N_CH'({req, req} >> ptr);

  always_comb begin
    offset = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = sel_t'(i);
      end
    end
  end

  assign any     = |req;
  assign gnt_idx = ptr + offset;

endmodule

// File: rtl/tdm_mux_16x1.sv
// Round-robin 16:1 TDM collector with a one-deep registered output stage.
// out_sel travels with each word so a downstream 1:16 demux can route it back out.
module tdm_mux_16x1
  import tdm_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  tdm_mux_16x1_if.slave bus
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  sel_t                sel_q, sel_d;
  sel_t                ptr_q, ptr_d;
  sel_t                gnt;
  logic                any;
  logic                can_load;
  logic                load;
  chan_vec_t           in_ready;

  rr_pick16 u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt),
    .any     (any)
  );

  assign can_load = (state_q == EMPTY) || bus.out_ready;
  assign load     = can_load && any;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    in_ready = '0;

    case (state_q)
      EMPTY:   if (any) state_d = FULL;
      FULL:    if (bus.out_ready && !any) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // A load while FULL overwrites the word being consumed, keeping one word per cycle.
    if (load) begin
      data_d = bus.in_data[gnt*DATA_W +: DATA_W];
      sel_d  = gnt;
      ptr_d  = gnt + sel_t'(1);
      if (rst_n) begin
        in_ready = sel_onehot(gnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.in_ready));

  // A stalled word must not move until the consumer takes it.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_sel) && $stable(bus.out_data)));

endmodule

// File: tb/tb_tdm_mux_16x1.sv
// Scoreboard bench for tdm_mux_16x1: a round-robin reference model predicts grants,
// a negedge monitor compares every presented word against the expected queue.
module tb_tdm_mux_16x1;

  typedef struct {
    int   sel;
    logic data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  int   model_ptr = 0;
  logic model_full = 1'b0;
  logic next_full = 1'b0;
  logic started = 1'b0;

  logic [15:0] pend_valid;
  logic [15:0] pend_data;

  tdm_mux_16x1_if bus ();

  tdm_mux_16x1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus: the model decides what the DUT must accept at the next edge.
  task automatic applyStimulus(input logic [15:0] valid, input logic [15:0] data,
                               input logic ready, output int granted);
    logic        can_load;
    logic [15:0] exp_ready;
    exp_t        e;
    @(posedge clk);
    model_full = next_full;
    #1;
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.out_ready = ready;
    #1;
    can_load = !model_full || ready;
    granted  = -1;
    if (can_load) begin
      for (int k = 0; k < 16; k++) begin
        if (granted < 0 && valid[(model_ptr + k) % 16]) granted = (model_ptr + k) % 16;
      end
    end
    exp_ready = (granted >= 0) ? (16'(1) << granted) : 16'h0000;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    if (granted >= 0) begin
      e.sel  = granted;
      e.data = data[granted];
      sb.push_back(e);
      model_ptr = (granted + 1) % 16;
      next_full = 1'b1;
    end else if (model_full && ready) begin
      next_full = 1'b0;
    end
  endtask

  // Async reset asserted between edges; the model and channel state are cleared with it.
  task automatic applyReset();
    @(posedge clk);
    #3;
    bus.in_valid  = 16'hFFFF;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    model_ptr  = 0;
    model_full = 1'b0;
    next_full  = 1'b0;
    pend_valid = '0;
    pend_data  = '0;
    bus.in_valid = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    started = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && started) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'(model_full));
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("scoreboard_has_word", 32'd0, 32'd1);
        end else begin
          checkOutput("out_sel", 32'(bus.out_sel), 32'(sb[0].sel));
          checkOutput("out_data", 32'(bus.out_data), 32'(sb[0].data));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int          g;
    logic        rdy;
    logic [15:0] y;
    logic [15:0] seen;

    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    pend_valid    = '0;
    pend_data     = '0;

    applyReset();

    // Full request load: strict 0..15,0 rotation, data alternating with channel parity.
    repeat (18) applyStimulus(16'hFFFF, 16'hAAAA, 1'b1, g);
    applyStimulus(16'h0000, 16'h0000, 1'b1, g);

    // Random traffic obeying the hold-until-accepted channel rule.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (!pend_valid[i] && $urandom_range(0, 3) == 0) begin
          pend_valid[i] = 1'b1;
          pend_data[i]  = 1'($urandom_range(0, 1));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(pend_valid, pend_data, rdy, g);
      if (g >= 0) pend_valid[g] = 1'b0;
    end

    // Reset mid-stream; first grant afterwards must come from channel 0.
    applyReset();
    repeat (3) applyStimulus(16'hFFFF, 16'h5555, 1'b1, g);

    // Sparse wrap: 0, 15, 0.
    applyReset();
    repeat (4) applyStimulus(16'h8001, 16'h8000, 1'b1, g);
    applyStimulus(16'h0000, 16'h0000, 1'b1, g);

    // Backpressure with out_sel=3 held, then 4 and 5 drain.
    applyReset();
    applyStimulus(16'h0008, 16'h0008, 1'b1, g);
    repeat (5) applyStimulus(16'h0030, 16'h0010, 1'b0, g);
    applyStimulus(16'h0030, 16'h0010, 1'b1, g);
    applyStimulus(16'h0020, 16'h0000, 1'b1, g);
    applyStimulus(16'h0000, 16'h0000, 1'b1, g);

    // Single word on channel 7 drains after one valid cycle.
    applyStimulus(16'h0080, 16'h0080, 1'b1, g);
    repeat (3) applyStimulus(16'h0000, 16'h0000, 1'b1, g);

    // End to end through a behavioural 1:16 demux: every output bit fires once in 16 cycles.
    seen = '0;
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, g);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, g);
      @(negedge clk);
      y = bus.out_valid ? (16'(bus.out_data) << bus.out_sel) : 16'h0000;
      checkOutput("demux_onehot", 32'($countones(y)), 32'd1);
      seen = seen | y;
    end
    checkOutput("demux_all_channels", 32'(seen), 32'h0000FFFF);

    repeat (3) applyStimulus(16'h0000, 16'h0000, 1'b1, g);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
